// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-bus-side signals of the shared memory port.
// The arbiter uses the slave modport; the pipeline/memory environment uses master.
interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_req;
  logic        d_write;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic [31:0] bus_ad;
  logic [31:0] bus_dt_out;
  logic        bus_dt_oe;
  logic [31:0] bus_dt_in;
  logic        bus_mreq;
  logic        bus_write;
  logic [1:0]  bus_size;
  logic        bus_ack_n;
  logic        busy;
  logic        timeout_err;

  modport slave (
    input  i_req, i_addr, d_req, d_write, d_size, d_addr, d_wdata,
    input  bus_dt_in, bus_ack_n,
    output i_rdata, i_done, d_rdata, d_done,
    output bus_ad, bus_dt_out, bus_dt_oe, bus_mreq, bus_write, bus_size,
    output busy, timeout_err
  );

  modport master (
    output i_req, i_addr, d_req, d_write, d_size, d_addr, d_wdata,
    output bus_dt_in, bus_ack_n,
    input  i_rdata, i_done, d_rdata, d_done,
    input  bus_ad, bus_dt_out, bus_dt_oe, bus_mreq, bus_write, bus_size,
    input  busy, timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store. Data wins by
// default; a grant streak limit keeps fetch from starving and a timeout aborts hung transfers.
module mem_port_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int            TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLIM = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [3:0]    SMAX = 4'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, I_XFER, D_XFER, DONE} state_t;

  state_t        r_state;
  logic [3:0]    r_streak;
  logic [TW-1:0] r_tcnt;
  logic [31:0]   r_bus_ad, r_bus_dt_out, r_i_rdata, r_d_rdata;
  logic [1:0]    r_bus_size;
  logic          r_bus_mreq, r_bus_write, r_bus_dt_oe;
  logic          r_i_done, r_d_done, r_timeout_err;
  logic          w_ack, w_tmo, w_d_win;

  assign w_ack   = ~bus.bus_ack_n;
  // Count equal to TIMEOUT-1 with no ack means this wait edge brings it to TIMEOUT.
  assign w_tmo   = (TIMEOUT > 0) && (r_tcnt == TLIM);
  assign w_d_win = bus.d_req && !(bus.i_req && (r_streak >= SMAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_streak      <= '0;
      r_tcnt        <= '0;
      r_bus_ad      <= '0;
      r_bus_dt_out  <= '0;
      r_bus_size    <= '0;
      r_bus_mreq    <= 1'b0;
      r_bus_write   <= 1'b0;
      r_bus_dt_oe   <= 1'b0;
      r_i_rdata     <= '0;
      r_d_rdata     <= '0;
      r_i_done      <= 1'b0;
      r_d_done      <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_d_win) begin
            r_state      <= D_XFER;
            r_tcnt       <= '0;
            r_bus_mreq   <= 1'b1;
            r_bus_ad     <= bus.d_addr;
            r_bus_write  <= bus.d_write;
            r_bus_size   <= bus.d_size;
            r_bus_dt_out <= bus.d_wdata;
            r_bus_dt_oe  <= bus.d_write;
            if (!bus.i_req)
              r_streak <= '0;
            else if (r_streak < SMAX)
              r_streak <= r_streak + 4'd1;
          end else if (bus.i_req) begin
            r_state     <= I_XFER;
            r_tcnt      <= '0;
            r_streak    <= '0;
            r_bus_mreq  <= 1'b1;
            r_bus_ad    <= bus.i_addr;
            r_bus_write <= 1'b0;
            r_bus_size  <= 2'b10;
            r_bus_dt_oe <= 1'b0;
          end
        end
        I_XFER, D_XFER: begin
          if (w_ack || w_tmo) begin
            r_state     <= DONE;
            r_bus_mreq  <= 1'b0;
            r_bus_write <= 1'b0;
            r_bus_dt_oe <= 1'b0;
            r_bus_ad    <= '0;
            if (r_state == I_XFER) r_i_done <= 1'b1;
            else                   r_d_done <= 1'b1;
            // An ack on the timeout edge still counts as a good completion.
            if (w_ack) begin
              if (r_state == I_XFER)  r_i_rdata <= bus.bus_dt_in;
              else if (!r_bus_write)  r_d_rdata <= bus.bus_dt_in;
            end else begin
              r_timeout_err <= 1'b1;
            end
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.i_rdata     = r_i_rdata;
  assign bus.i_done      = r_i_done;
  assign bus.d_rdata     = r_d_rdata;
  assign bus.d_done      = r_d_done;
  assign bus.bus_ad      = r_bus_ad;
  assign bus.bus_dt_out  = r_bus_dt_out;
  assign bus.bus_dt_oe   = r_bus_dt_oe;
  assign bus.bus_mreq    = r_bus_mreq;
  assign bus.bus_write   = r_bus_write;
  assign bus.bus_size    = r_bus_size;
  assign bus.busy        = (r_state != IDLE);
  assign bus.timeout_err = r_timeout_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: completions are checked against a queue of
// expected (requester, rdata) entries pushed when each transfer is acknowledged.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if u_if ();

  mem_port_arbiter #(.MAX_D_STREAK(4), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  typedef struct packed {
    logic        is_d;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] m_i_rdata = '0;
  logic [31:0] m_d_rdata = '0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic await_done(input int budget);
    exp_t e;
    logic seen;
    for (int k = 0; k < budget && !(u_if.i_done || u_if.d_done); k++) tick();
    seen = u_if.i_done | u_if.d_done;
    chk("done_seen", {31'b0, seen}, 32'd1);
    if (seen) begin
      chk("sb_nonempty", {31'b0, (sb_q.size() != 0)}, 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("done_who", {31'b0, u_if.d_done}, {31'b0, e.is_d});
        chk("done_rdata", e.is_d ? u_if.d_rdata : u_if.i_rdata, e.data);
      end
    end
  endtask

  // One complete transfer starting from IDLE with no other request pending.
  task automatic xfer(input bit is_d, input bit wr, input logic [1:0] sz,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input int wait_n, input logic [31:0] rd);
    if (is_d) begin
      u_if.d_req = 1'b1; u_if.d_write = wr; u_if.d_size = sz;
      u_if.d_addr = addr; u_if.d_wdata = wdata;
    end else begin
      u_if.i_req = 1'b1; u_if.i_addr = addr;
    end
    tick();
    chk("x_mreq", {31'b0, u_if.bus_mreq}, 32'd1);
    chk("x_busy", {31'b0, u_if.busy}, 32'd1);
    chk("x_ad", u_if.bus_ad, addr);
    chk("x_size", {30'b0, u_if.bus_size}, {30'b0, (is_d ? sz : 2'b10)});
    chk("x_write", {31'b0, u_if.bus_write}, {31'b0, is_d & wr});
    chk("x_oe", {31'b0, u_if.bus_dt_oe}, {31'b0, is_d & wr});
    if (is_d && wr) chk("x_dt_out", u_if.bus_dt_out, wdata);
    u_if.bus_dt_in = 32'hBAD0_BAD0;
    repeat (wait_n) tick();
    chk("x_ad_hold", u_if.bus_ad, addr);
    u_if.bus_ack_n = 1'b0; u_if.bus_dt_in = rd;
    tick();
    u_if.bus_ack_n = 1'b1; u_if.bus_dt_in = '0;
    if (!is_d)   m_i_rdata = rd;
    else if (!wr) m_d_rdata = rd;
    sb_q.push_back('{is_d: is_d, data: (is_d ? m_d_rdata : m_i_rdata)});
    await_done(3);
    chk("x_done_mreq", {31'b0, u_if.bus_mreq}, 32'd0);
    chk("x_done_ad", u_if.bus_ad, 32'd0);
    if (is_d) u_if.d_req = 1'b0; else u_if.i_req = 1'b0;
    tick();
    chk("x_idle_busy", {31'b0, u_if.busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] pat;
    logic       exp_d;
    int         n;

    rst = 1'b1;
    u_if.i_req = 0; u_if.i_addr = '0; u_if.d_req = 0; u_if.d_write = 0;
    u_if.d_size = '0; u_if.d_addr = '0; u_if.d_wdata = '0;
    u_if.bus_dt_in = '0; u_if.bus_ack_n = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_busy", {31'b0, u_if.busy}, 32'd0);
    chk("rst_mreq", {31'b0, u_if.bus_mreq}, 32'd0);
    chk("rst_done", {30'b0, u_if.i_done, u_if.d_done}, 32'd0);
    chk("rst_terr", {31'b0, u_if.timeout_err}, 32'd0);
    chk("rst_ad", u_if.bus_ad, 32'd0);

    // Simple fetch, ack on the cycle after the grant.
    xfer(1'b0, 1'b0, 2'b10, 32'h100, '0, 0, 32'h0050_0093);

    // Simultaneous requests: the store goes first, then the fetch.
    u_if.i_req = 1'b1; u_if.i_addr = 32'h300;
    u_if.d_req = 1'b1; u_if.d_write = 1'b1; u_if.d_size = 2'b10;
    u_if.d_addr = 32'h2000; u_if.d_wdata = 32'hDEAD_BEEF;
    tick();
    chk("both_ad", u_if.bus_ad, 32'h2000);
    chk("both_oe", {31'b0, u_if.bus_dt_oe}, 32'd1);
    chk("both_dt_out", u_if.bus_dt_out, 32'hDEAD_BEEF);
    u_if.bus_ack_n = 1'b0;
    tick();
    u_if.bus_ack_n = 1'b1;
    sb_q.push_back('{is_d: 1'b1, data: m_d_rdata});
    await_done(2);
    u_if.d_req = 1'b0;
    tick();
    xfer(1'b0, 1'b0, 2'b10, 32'h300, '0, 1, 32'h1111_1111);

    // Streak limit: fetch held, data always pending -> D D D D I D.
    pat = 6'b101111;
    u_if.i_req = 1'b1; u_if.i_addr = 32'h400;
    u_if.d_req = 1'b1; u_if.d_write = 1'b0; u_if.d_size = 2'b10; u_if.d_addr = 32'h3000;
    for (int g = 0; g < 6; g++) begin
      exp_d = pat[g];
      tick();
      chk("streak_ad", u_if.bus_ad, exp_d ? 32'h3000 : 32'h400);
      u_if.bus_ack_n = 1'b0; u_if.bus_dt_in = 32'hA000_0000 + g;
      tick();
      u_if.bus_ack_n = 1'b1;
      if (exp_d) m_d_rdata = 32'hA000_0000 + g; else m_i_rdata = 32'hA000_0000 + g;
      sb_q.push_back('{is_d: exp_d, data: (exp_d ? m_d_rdata : m_i_rdata)});
      await_done(2);
      if (g == 5) begin u_if.i_req = 1'b0; u_if.d_req = 1'b0; end
      tick();
    end

    // Store with a narrow size leaves d_rdata alone.
    xfer(1'b1, 1'b1, 2'b01, 32'h4000, 32'h0000_00AB, 2, 32'h5555_5555);
    chk("store_keeps_rdata", u_if.d_rdata, m_d_rdata);

    // Ack on the same edge the timeout would fire: capture, no error.
    xfer(1'b1, 1'b0, 2'b10, 32'h4100, '0, 7, 32'h1234_5678);
    chk("edge_ack_terr", {31'b0, u_if.timeout_err}, 32'd0);

    // Hung load: mreq for 8 cycles, then abort without capture.
    u_if.d_req = 1'b1; u_if.d_write = 1'b0; u_if.d_size = 2'b10; u_if.d_addr = 32'h5000;
    u_if.bus_dt_in = 32'hBAD0_BAD0;
    tick();
    n = 0;
    while (u_if.bus_mreq && n < 20) begin n++; tick(); end
    chk("tmo_cycles", n, 32'd8);
    sb_q.push_back('{is_d: 1'b1, data: m_d_rdata});
    await_done(1);
    chk("tmo_err_set", {31'b0, u_if.timeout_err}, 32'd1);
    u_if.d_req = 1'b0; u_if.bus_dt_in = '0;
    tick();
    xfer(1'b0, 1'b0, 2'b10, 32'h600, '0, 0, 32'h0BAD_F00D);
    chk("tmo_err_sticky", {31'b0, u_if.timeout_err}, 32'd1);

    // Reset in the middle of a data transfer.
    u_if.d_req = 1'b1; u_if.d_write = 1'b0; u_if.d_addr = 32'h6000;
    tick();
    chk("mid_mreq", {31'b0, u_if.bus_mreq}, 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_mreq", {31'b0, u_if.bus_mreq}, 32'd0);
    chk("mid_rst_busy", {31'b0, u_if.busy}, 32'd0);
    chk("mid_rst_done", {30'b0, u_if.i_done, u_if.d_done}, 32'd0);
    chk("mid_rst_terr", {31'b0, u_if.timeout_err}, 32'd0);
    chk("mid_rst_rdata", u_if.d_rdata, 32'd0);
    m_i_rdata = '0; m_d_rdata = '0;
    rst = 1'b0; u_if.d_req = 1'b0;
    xfer(1'b0, 1'b0, 2'b10, 32'h700, '0, 1, 32'h7777_0001);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
